discount_factor_pipe: RTL and testbench

- Pipelined Black-Scholes discounting stage that wraps the combinational `exp` block.
- Builds the exponent argument x = -(r*T) in Q6.10, drives `exp`, registers the result, and multiplies by strike K to produce the present value K*exp(-rT).
- Uses a valid/ready stream on both sides and sits between the option-parameter feeder and the d1/d2 and price-combine stages.

---
 rtl/discount_factor_pipe.sv | 198 +++++++++++++++++++
 tb/tb_discount_factor_pipe.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/discount_factor_pipe.sv
// discount_factor_pipe: present value K*exp(-r*T) and discount factor exp(-r*T), signed Q6.10.
// Latency 3 cycles (S1 exponent argument, S2 exp, S3 strike multiply); one result per cycle.
// Backpressure: each stage advances when the stage after it can take data, so bubbles collapse and in_ready follows out_ready combinationally.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake for r_in (rate), t_in (expiry), k_in (strike)
//   out_valid / out_ready result handshake for df_out, pv_out, sat_out
//   sat_count             saturating count of results delivered with sat_out=1
//                         (present only when DISCOUNT_SAT_STATS_EN is defined)
//
// The exp block below evaluates 2^(x*log2(e)): the integer part of the base-2
// exponent becomes a shift, the fractional part f a quadratic mantissa
// 1 + f*(0.656 + 0.344*f). Its constants assume 10 fractional bits.

`timescale 1ns/1ps

module discount_factor_pipe #(
    parameter int W    = 16,
    parameter int FRAC = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] r_in,
    input  logic [W-1:0] t_in,
    input  logic [W-1:0] k_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] df_out,
    output logic [W-1:0] pv_out,
    output logic         sat_out
`ifdef DISCOUNT_SAT_STATS_EN
    ,
    output logic [15:0]  sat_count
`endif
);

    typedef logic signed [2*W-1:0] prod_t;

    localparam prod_t HALF = prod_t'(1) <<< (FRAC - 1);
    localparam prod_t PMAX = prod_t'({1'b0, {(W-1){1'b1}}});
    localparam prod_t PMIN = -PMAX - prod_t'(1);
    localparam logic [W-1:0] WMIN = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] WMAX = {1'b0, {(W-1){1'b1}}};

    // Round-to-nearest (ties toward +inf) then clamp to W bits; MSB of the
    // result flags that the clamp fired.
    function automatic logic [W:0] round_sat(input prod_t p);
        prod_t r;
        r = (p + HALF) >>> FRAC;
        if (r > PMAX) begin
            return {1'b1, PMAX[W-1:0]};
        end else if (r < PMIN) begin
            return {1'b1, PMIN[W-1:0]};
        end else begin
            return {1'b0, r[W-1:0]};
        end
    endfunction

    logic en1, en2, en3;
    logic v1, v2;

    logic [W-1:0] arg1, k1, df2, k2, exp_y;
    logic         sat1, sat2;

    logic [W:0]   prod1_rs, prod3_rs;
    logic [W-1:0] arg_nxt;
    logic         sat_nxt;

    assign en3      = out_ready || !out_valid;
    assign en2      = en3 || !v2;
    assign en1      = en2 || !v1;
    assign in_ready = en1;

    // S1: x = -(r*T). Negating the most negative value would wrap, so it is
    // pinned to the most positive value and counted as a saturation.
    always_comb begin
        prod1_rs = round_sat(prod_t'($signed(r_in)) * prod_t'($signed(t_in)));
        sat_nxt  = prod1_rs[W];
        arg_nxt  = ~prod1_rs[W-1:0] + W'(1);
        if (prod1_rs[W-1:0] == WMIN) begin
            arg_nxt = WMAX;
            sat_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1   <= 1'b0;
            arg1 <= '0;
            k1   <= '0;
            sat1 <= 1'b0;
        end else if (en1) begin
            v1   <= in_valid;
            arg1 <= arg_nxt;
            k1   <= k_in;
            sat1 <= sat_nxt;
        end
    end

    // S2: exponential of the registered argument.
    exp #(.W(W)) u_exp (
        .x_in    (arg1),
        .exp_out (exp_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2   <= 1'b0;
            df2  <= '0;
            k2   <= '0;
            sat2 <= 1'b0;
        end else if (en2) begin
            v2   <= v1;
            df2  <= exp_y;
            k2   <= k1;
            sat2 <= sat1;
        end
    end

    // S3: present value = K * discount factor.
    always_comb begin
        prod3_rs = round_sat(prod_t'($signed(k2)) * prod_t'($signed(df2)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            df_out    <= '0;
            pv_out    <= '0;
            sat_out   <= 1'b0;
        end else if (en3) begin
            out_valid <= v2;
            df_out    <= df2;
            pv_out    <= prod3_rs[W-1:0];
            sat_out   <= sat2 | prod3_rs[W];
        end
    end

`ifdef DISCOUNT_SAT_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_count <= '0;
        end else if (out_valid && out_ready && sat_out && (sat_count != 16'hFFFF)) begin
            sat_count <= sat_count + 16'd1;
        end
    end
`endif

endmodule

// exp: combinational e^x for a signed Q.10 operand, result Q.10 clamped to [0, 2^(W-1)-1].
// Latency 0 (pure combinational).
// Backpressure: none; the surrounding pipeline stage owns flow control.
module exp #(
    parameter int W = 16
) (
    input  logic [W-1:0] x_in,
    output logic [W-1:0] exp_out
);

    localparam logic [31:0] YMAX = 32'((64'd1 << (W - 1)) - 64'd1);

    logic signed [31:0] xs, y, n;
    logic [31:0]        f, c, m, sh, t;

    always_comb begin
        xs = 32'($signed(x_in));
        // y = x*log2(e) in Q.10; n is its floor, f the non-negative fraction.
        y  = (xs * 32'sd1477) >>> 10;
        n  = y >>> 10;
        f  = {22'd0, y[9:0]};
        c  = 32'd672 + ((32'd352 * f) >> 10);
        m  = 32'd1024 + ((f * c) >> 10);
        sh = 32'd0;
        t  = 32'd0;
        exp_out = '0;
        if (!n[31]) begin
            if (n > 32'sd15) begin
                exp_out = YMAX[W-1:0];
            end else begin
                t       = m << n[3:0];
                exp_out = (t > YMAX) ? YMAX[W-1:0] : t[W-1:0];
            end
        end else begin
            // Right shift with rounding; the mantissa is below 2^11, so shifts
            // of 12 or more always round to zero.
            sh = $unsigned(-n);
            if (sh < 32'd12) begin
                t       = (m + (32'd1 << (sh[3:0] - 4'd1))) >> sh[3:0];
                exp_out = t[W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_discount_factor_pipe.sv
// tb_discount_factor_pipe: checks discount_factor_pipe against hand-derived vectors and an arithmetic model.
// Latency of the design is expected to be 3 edges counting the accepting edge.
// Backpressure is exercised with a fixed stall window and with random out_ready.

`timescale 1ns/1ps

module tb_discount_factor_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, sat_out;
    logic [15:0] r_in, t_in, k_in, df_out, pv_out;
`ifdef DISCOUNT_SAT_STATS_EN
    logic [15:0] sat_count;
    int          exp_cnt = 0;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct { int r; int t; int k; int df; int pv; bit sat; } vec_t;
    typedef struct { int df; int pv; bit sat; } res_t;

    vec_t vecs[8];
    res_t expq[$];

    always #5 clk = ~clk;

    discount_factor_pipe #(.W(16), .FRAC(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .r_in      (r_in),
        .t_in      (t_in),
        .k_in      (k_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .df_out    (df_out),
        .pv_out    (pv_out),
        .sat_out   (sat_out)
`ifdef DISCOUNT_SAT_STATS_EN
        ,
        .sat_count (sat_count)
`endif
    );

    task automatic chk(input string name, input longint act, input longint exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int fdiv(input int a, input int b);
        int q;
        q = a / b;
        if ((a % b) != 0 && a < 0) q = q - 1;
        return q;
    endfunction

    function automatic int clamp16(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // e^(x/1024)*1024 taken as 2^(x*log2 e) with a quadratic 2^f mantissa.
    function automatic int exp_model(input int x);
        int y, n, f, m;
        longint v;
        y = fdiv(x * 1477, 1024);
        n = fdiv(y, 1024);
        f = y - n * 1024;
        m = 1024 + (f * (672 + (352 * f) / 1024)) / 1024;
        if (n >= 0) begin
            v = (n > 15) ? 64'sd32767 : longint'(m) * (longint'(1) << n);
            if (v > 32767) v = 32767;
        end else if (-n >= 30) begin
            v = 0;
        end else begin
            v = (longint'(m) + (longint'(1) << (-n - 1))) / (longint'(1) << (-n));
        end
        return int'(v);
    endfunction

    function automatic res_t model(input int r, input int t, input int k);
        res_t res;
        int   rp, a, arg, pq;
        bit   s;
        rp  = fdiv(r * t + 512, 1024);
        a   = clamp16(rp);
        s   = (a != rp);
        arg = -a;
        if (arg > 32767) begin
            arg = 32767;
            s   = 1'b1;
        end
        res.df  = exp_model(arg);
        pq      = fdiv(k * res.df + 512, 1024);
        res.pv  = clamp16(pq);
        res.sat = s | (res.pv != pq);
        return res;
    endfunction

    function automatic logic [15:0] rnd_op();
        case ($urandom_range(0, 3))
            0:       return 16'($urandom);
            1:       return 16'($urandom_range(0, 4096));
            2:       return 16'(-int'($urandom_range(0, 2048)));
            default: return 16'($urandom_range(0, 1024));
        endcase
    endfunction

    // ---------------- single-transaction vector ----------------
    task automatic apply_vec(input int i);
        int lat;
        @(negedge clk);
        r_in      = 16'(vecs[i].r);
        t_in      = 16'(vecs[i].t);
        k_in      = 16'(vecs[i].k);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1 chk($sformatf("vec%0d_in_ready", i), in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        chk($sformatf("vec%0d_latency", i), lat, 3);
        chk($sformatf("vec%0d_df", i), $signed(df_out), vecs[i].df);
        chk($sformatf("vec%0d_pv", i), $signed(pv_out), vecs[i].pv);
        chk($sformatf("vec%0d_sat", i), sat_out, vecs[i].sat);
`ifdef DISCOUNT_SAT_STATS_EN
        if (vecs[i].sat) exp_cnt++;
`endif
    endtask

    // ---------------- streaming with scoreboard ----------------
    task automatic run_stream(input int ncyc, input bit rnd,
                              output int n_sent, output int n_recv, output bit saw_block);
        res_t        e;
        bit          held;
        logic [15:0] h_df, h_pv;
        logic        h_sat;
        held = 1'b0; h_df = '0; h_pv = '0; h_sat = 1'b0;
        n_sent = 0; n_recv = 0; saw_block = 1'b0;
        for (int c = 0; c < ncyc + 40; c++) begin
            @(negedge clk);
            #1;
            if (c < ncyc) begin
                if (rnd) begin
                    in_valid  = ($urandom_range(0, 9) < 7);
                    out_ready = ($urandom_range(0, 9) < 7);
                    r_in = rnd_op();
                    t_in = rnd_op();
                    k_in = 16'($urandom);
                end else begin
                    in_valid  = (n_sent < 6);
                    out_ready = !(c >= 4 && c <= 8);
                    r_in = 16'(vecs[n_sent % 8].r);
                    t_in = 16'(vecs[n_sent % 8].t);
                    k_in = 16'(vecs[n_sent % 8].k);
                end
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            #1;
            if (held)
                chk("hold_stable", {out_valid, df_out, pv_out, sat_out}, {1'b1, h_df, h_pv, h_sat});
            if (in_valid && in_ready) begin
                expq.push_back(model($signed(r_in), $signed(t_in), $signed(k_in)));
                n_sent++;
            end
            if (in_valid && !in_ready) saw_block = 1'b1;
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    chk("spurious_out", 1, 0);
                end else begin
                    e = expq.pop_front();
                    chk("stream_df", $signed(df_out), e.df);
                    chk("stream_pv", $signed(pv_out), e.pv);
                    chk("stream_sat", sat_out, e.sat);
`ifdef DISCOUNT_SAT_STATS_EN
                    if (e.sat) exp_cnt++;
`endif
                end
                n_recv++;
            end
            held  = out_valid && !out_ready;
            h_df  = df_out;
            h_pv  = pv_out;
            h_sat = sat_out;
            if (c >= ncyc && expq.size() == 0) break;
        end
        chk("stream_drained", expq.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent, recv, lat;
        bit blk, stale;

        vecs[0] = '{51,     1024, 10240, 975,   9750,  1'b0};
        vecs[1] = '{20480,  2048, 1024,  0,     0,     1'b1};
        vecs[2] = '{-2048,  1536, 31744, 20496, 32767, 1'b1};
        vecs[3] = '{0,      5000, 1024,  1024,  1024,  1'b0};
        vecs[4] = '{-32768, 1024, 1024,  32767, 32767, 1'b1};
        vecs[5] = '{1024,   1024, 2048,  377,   754,   1'b0};
        vecs[6] = '{1024,   1024, -2048, 377,   -754,  1'b0};
        vecs[7] = '{-512,   1024, 1024,  1690,  1690,  1'b0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        r_in = '0; t_in = '0; k_in = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_df", df_out, 0);
        chk("reset_pv", pv_out, 0);
        chk("reset_sat", sat_out, 0);
        chk("reset_in_ready", in_ready, 1);
`ifdef DISCOUNT_SAT_STATS_EN
        chk("reset_sat_count", sat_count, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) apply_vec(i);

        // Six back-to-back operands with out_ready low for cycles 4-8.
        run_stream(12, 1'b0, sent, recv, blk);
        chk("bp_sent", sent, 6);
        chk("bp_recv", recv, 6);
        chk("bp_in_ready_dropped", blk, 1);

        // Reset with two results in flight, one already presented.
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1;
        r_in = 16'(vecs[5].r); t_in = 16'(vecs[5].t); k_in = 16'(vecs[5].k);
        @(negedge clk);
        r_in = 16'(vecs[7].r); t_in = 16'(vecs[7].t); k_in = 16'(vecs[7].k);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        chk("rst_pre_out_valid", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_out_valid", out_valid, 0);
        chk("rst_async_df", df_out, 0);
        chk("rst_async_pv", pv_out, 0);
`ifdef DISCOUNT_SAT_STATS_EN
        exp_cnt = 0;
`endif
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        stale = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) stale = 1'b1;
        end
        chk("rst_no_stale_result", stale, 0);
        apply_vec(3);
        apply_vec(2);

        run_stream(400, 1'b1, sent, recv, blk);
        chk("rand_recv_eq_sent", recv, sent);

        @(negedge clk);
`ifdef DISCOUNT_SAT_STATS_EN
        chk("sat_count_final", sat_count, exp_cnt);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
